// File: rtl/clock_ui_pkg.sv
//==============================================================================
// Module   : clock_ui_pkg
// Purpose  : Shared types and constants for the clock's edit user interface.
//            Holds the RUN/EDIT state encoding, the digit-position codes
//            driven on edit_pos, and the auto-repeat timing constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package clock_ui_pkg;

   // Top-level UI mode
   typedef enum logic {
      RUN  = 1'b0,
      EDIT = 1'b1
   } ui_state_t;

   // Digit positions on edit_pos, left to right on the display
   localparam logic [2:0] POS_H10 = 3'd0;
   localparam logic [2:0] POS_H1  = 3'd1;
   localparam logic [2:0] POS_M10 = 3'd2;
   localparam logic [2:0] POS_M1  = 3'd3;
   localparam logic [2:0] POS_S10 = 3'd4;
   localparam logic [2:0] POS_S1  = 3'd5;

   // Auto-repeat timing (0.5 s initial delay, 0.1 s rate at 50 MHz)
   localparam int REPEAT_DELAY  = 25_000_000;
   localparam int REPEAT_PERIOD = 5_000_000;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
//==============================================================================
// Module   : key_debounce
// Purpose  : One panel button: 2-FF synchronizer, stability counter,
//            debounced level and a one-cycle press pulse on the debounced
//            released->pressed transition.
// Ports    : clk     - system clock
//            reset   - asynchronous, active-low
//            btn_n   - raw button, active-low, asynchronous to clk
//            level   - debounced level (1 = released)
//            press   - one-cycle pulse when the debounced level falls
// Params   : DEBOUNCE_CYCLES - consecutive equal samples needed to accept
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic level,
   output logic press
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic             sync_q1;
   logic             sync_q2;
   logic             armed;
   logic [CNT_W-1:0] cnt;

   // The synchronizer resets to "pressed" so that a released sample can only
   // come from the real pin. The press pulse is armed only after such a
   // sample, which keeps a button held across reset from firing until it has
   // been let go and pressed again.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         armed   <= 1'b0;
         cnt     <= '0;
         level   <= 1'b1;
         press   <= 1'b0;
      end else begin
         sync_q1 <= btn_n;
         sync_q2 <= sync_q1;
         armed   <= armed | sync_q2;
         press   <= 1'b0;
         if (sync_q2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync_q2;
            press <= armed & ~sync_q2;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/edit_key_controller.sv
//==============================================================================
// Module   : edit_key_controller
// Purpose  : Front end of the clock's edit interface. Debounces the four
//            panel buttons, runs the RUN/EDIT mode machine, tracks the
//            selected digit and display screen, and issues one-cycle
//            increment/decrement strobes for the time counters.
// Ports    : clk         - system clock
//            reset       - asynchronous, active-low
//            btn_mode_n  - raw MODE button, active-low
//            btn_next_n  - raw NEXT button, active-low
//            btn_plus_n  - raw PLUS button, active-low
//            btn_minus_n - raw MINUS button, active-low
//            edit_mode   - 1 while in EDIT
//            edit_pos    - selected digit (0 = H tens ... 5 = S ones)
//            screen      - active display screen, 0..NUM_SCREENS-1
//            key_plus    - one-cycle increment strobe
//            key_minus   - one-cycle decrement strobe
//            blink       - flash enable for the selected digit
// Macro    : EDIT_AUTOREPEAT_EN - when defined, a held PLUS/MINUS in EDIT
//            repeats its strobe after REPEAT_DELAY, then every REPEAT_PERIOD.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module edit_key_controller
   import clock_ui_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TIMEOUT_CYCLES  = 500_000_000,
   parameter int BLINK_CYCLES    = 12_500_000,
   parameter int NUM_SCREENS     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode_n,
   input  logic       btn_next_n,
   input  logic       btn_plus_n,
   input  logic       btn_minus_n,
   output logic       edit_mode,
   output logic [2:0] edit_pos,
   output logic [1:0] screen,
   output logic       key_plus,
   output logic       key_minus,
   output logic       blink
);

   localparam int KEY_MODE  = 0;
   localparam int KEY_NEXT  = 1;
   localparam int KEY_PLUS  = 2;
   localparam int KEY_MINUS = 3;

   localparam int                 IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDLE_W-1:0]  IDLE_ONE   = IDLE_W'(1);
   localparam int                 BLINK_W    = $clog2(BLINK_CYCLES + 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
   localparam logic [1:0]         SCR_LAST   = 2'(NUM_SCREENS - 1);

   logic [3:0]         btn_raw;
   logic [3:0]         level;
   logic [3:0]         press;
   logic               rpt_plus;
   logic               rpt_minus;
   logic               strobe_plus;
   logic               strobe_minus;
   logic               any_event;
   logic               unused_levels;
   ui_state_t          state;
   logic [IDLE_W-1:0]  idle_cnt;
   logic [BLINK_W-1:0] blink_cnt;

   assign btn_raw = {btn_minus_n, btn_plus_n, btn_next_n, btn_mode_n};

   for (genvar i = 0; i < 4; i++) begin : g_debounce
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debounce (
         .clk   (clk),
         .reset (reset),
         .btn_n (btn_raw[i]),
         .level (level[i]),
         .press (press[i])
      );
   end

   // Only the auto-repeat logic looks at levels; the FSM works on presses.
   assign unused_levels = ^level;

`ifdef EDIT_AUTOREPEAT_EN
   localparam int               RPT_W           = $clog2(REPEAT_DELAY + 1);
   localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
   localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_active;
   logic             held_plus;
   logic             held_minus;
   logic             rpt_hold;
   logic             rpt_fire;

   // Repeat only while exactly one of PLUS/MINUS is held, since holding both
   // would never have produced a strobe in the first place.
   assign held_plus  = ~level[KEY_PLUS] &  level[KEY_MINUS];
   assign held_minus =  level[KEY_PLUS] & ~level[KEY_MINUS];
   assign rpt_hold   = (state == EDIT) & (held_plus | held_minus);
   assign rpt_fire   = rpt_hold & (rpt_active ? (rpt_cnt == RPT_PERIOD_LAST)
                                              : (rpt_cnt == RPT_DELAY_LAST));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rpt_cnt    <= '0;
         rpt_active <= 1'b0;
      end else if (!rpt_hold) begin
         rpt_cnt    <= '0;
         rpt_active <= 1'b0;
      end else if (rpt_fire) begin
         rpt_cnt    <= '0;
         rpt_active <= 1'b1;
      end else begin
         rpt_cnt <= rpt_cnt + RPT_ONE;
      end
   end

   assign rpt_plus  = rpt_fire & held_plus;
   assign rpt_minus = rpt_fire & held_minus;
`else
   assign rpt_plus  = 1'b0;
   assign rpt_minus = 1'b0;
`endif

   // Simultaneous PLUS and MINUS cancel each other out.
   assign strobe_plus  = (press[KEY_PLUS]  & ~press[KEY_MINUS]) | rpt_plus;
   assign strobe_minus = (press[KEY_MINUS] & ~press[KEY_PLUS])  | rpt_minus;
   assign any_event    = (|press) | rpt_plus | rpt_minus;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         edit_mode <= 1'b0;
         edit_pos  <= POS_S1;
         screen    <= 2'd0;
         key_plus  <= 1'b0;
         key_minus <= 1'b0;
         blink     <= 1'b0;
         idle_cnt  <= '0;
         blink_cnt <= '0;
      end else begin
         key_plus  <= 1'b0;
         key_minus <= 1'b0;
         case (state)
            RUN: begin
               blink     <= 1'b0;
               blink_cnt <= '0;
               idle_cnt  <= '0;
               if (press[KEY_MODE]) begin
                  state     <= EDIT;
                  edit_mode <= 1'b1;
                  edit_pos  <= POS_S1;
                  blink     <= 1'b1;
               end else if (press[KEY_NEXT]) begin
                  screen <= (screen == SCR_LAST) ? 2'd0 : screen + 2'd1;
               end
            end

            EDIT: begin
               if (blink_cnt == BLINK_LAST) begin
                  blink     <= ~blink;
                  blink_cnt <= '0;
               end else begin
                  blink_cnt <= blink_cnt + BLINK_ONE;
               end

               if (press[KEY_MODE]) begin
                  state     <= RUN;
                  edit_mode <= 1'b0;
                  blink     <= 1'b0;
                  blink_cnt <= '0;
                  idle_cnt  <= '0;
               end else if (any_event) begin
                  // Any activity, including a discarded PLUS+MINUS pair,
                  // counts as the user still being at the panel.
                  idle_cnt <= '0;
                  if (press[KEY_NEXT]) begin
                     edit_pos <= (edit_pos == POS_H10) ? POS_S1 : edit_pos - 3'd1;
                  end else begin
                     key_plus  <= strobe_plus;
                     key_minus <= strobe_minus;
                  end
               end else if (idle_cnt == IDLE_LAST) begin
                  state     <= RUN;
                  edit_mode <= 1'b0;
                  blink     <= 1'b0;
                  blink_cnt <= '0;
                  idle_cnt  <= '0;
               end else begin
                  idle_cnt <= idle_cnt + IDLE_ONE;
               end
            end

            default: begin
               state     <= RUN;
               edit_mode <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_edit_key_controller.sv
//==============================================================================
// Module   : tb_edit_key_controller
// Purpose  : Self-checking bench for edit_key_controller. Directed presses
//            push expected output events into a scoreboard queue; a monitor
//            on the falling edge pops and compares whenever the DUT shows a
//            strobe or a change of edit_mode/edit_pos/screen.
// Ports    : none
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_edit_key_controller;

   localparam int D = 4;
   localparam int T = 50;
   localparam int B = 3;
   localparam int LAT = D + 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] btn_n = 4'hF;   // {minus, plus, next, mode}
   logic       edit_mode;
   logic [2:0] edit_pos;
   logic [1:0] screen;
   logic       key_plus;
   logic       key_minus;
   logic       blink;

   edit_key_controller #(
      .DEBOUNCE_CYCLES (D),
      .TIMEOUT_CYCLES  (T),
      .BLINK_CYCLES    (B),
      .NUM_SCREENS     (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_mode_n  (btn_n[0]),
      .btn_next_n  (btn_n[1]),
      .btn_plus_n  (btn_n[2]),
      .btn_minus_n (btn_n[3]),
      .edit_mode   (edit_mode),
      .edit_pos    (edit_pos),
      .screen      (screen),
      .key_plus    (key_plus),
      .key_minus   (key_minus),
      .blink       (blink)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       em;
      logic [2:0] pos;
      logic [1:0] scr;
      logic       kp;
      logic       km;
      int         at;   // expected cycle, -1 = any
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Monitor state
   logic       p_em = 1'b0;
   logic [2:0] p_pos = 3'd5;
   logic [1:0] p_scr = 2'd0;
   logic       ref_blink = 1'b0;
   int         ref_bcnt = 0;

   always @(negedge clk) begin
      exp_t e;

      checks++;
      if ((key_plus && key_minus) || (!edit_mode && (key_plus || key_minus))) begin
         errors++;
         $display("FAIL strobe_rule: cycle %0d key_plus=%b key_minus=%b edit_mode=%b, required never both and none in RUN",
                  cyc, key_plus, key_minus, edit_mode);
      end

      if (!edit_mode) begin
         ref_blink = 1'b0;
         ref_bcnt  = 0;
      end else if (!p_em) begin
         ref_blink = 1'b1;
         ref_bcnt  = 0;
      end else if (ref_bcnt == B - 1) begin
         ref_blink = ~ref_blink;
         ref_bcnt  = 0;
      end else begin
         ref_bcnt++;
      end
      checks++;
      if (blink !== ref_blink) begin
         errors++;
         $display("FAIL blink: cycle %0d got %b, required %b", cyc, blink, ref_blink);
      end

      if (key_plus || key_minus || edit_mode !== p_em || edit_pos !== p_pos || screen !== p_scr) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: cycle %0d em=%b pos=%0d scr=%0d kp=%b km=%b, required no event",
                     cyc, edit_mode, edit_pos, screen, key_plus, key_minus);
         end else begin
            e = sb.pop_front();
            if (edit_mode !== e.em || edit_pos !== e.pos || screen !== e.scr ||
                key_plus !== e.kp || key_minus !== e.km || (e.at >= 0 && cyc != e.at)) begin
               errors++;
               $display("FAIL event: got em=%b pos=%0d scr=%0d kp=%b km=%b at cycle %0d, required em=%b pos=%0d scr=%0d kp=%b km=%b at cycle %0d",
                        edit_mode, edit_pos, screen, key_plus, key_minus, cyc,
                        e.em, e.pos, e.scr, e.kp, e.km, e.at);
            end
         end
         p_em  = edit_mode;
         p_pos = edit_pos;
         p_scr = screen;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic em, input logic [2:0] pos, input logic [1:0] scr,
                       input logic kp, input logic km, input int at);
      exp_t e;
      e.em = em; e.pos = pos; e.scr = scr; e.kp = kp; e.km = km; e.at = at;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic press(input int k, input int hold, input int rel);
      btn_n[k] = 1'b0;
      step(hold);
      btn_n[k] = 1'b1;
      step(rel);
   endtask

   task automatic check_reset_values();
      chk("rst_edit_mode", int'(edit_mode), 0);
      chk("rst_edit_pos",  int'(edit_pos),  5);
      chk("rst_screen",    int'(screen),    0);
      chk("rst_key_plus",  int'(key_plus),  0);
      chk("rst_key_minus", int'(key_minus), 0);
      chk("rst_blink",     int'(blink),     0);
   endtask

   initial begin
      int n;

      step(4);
      check_reset_values();
      #2 reset = 1'b1;
      step(6);

      // MODE press in RUN: EDIT with pos 5 exactly D+3 edges after raw edge
      push(1'b1, 3'd5, 2'd0, 1'b0, 1'b0, cyc + LAT);
      press(0, 10, 12);

      // NEXT x6 in EDIT: pos 4,3,2,1,0,5
      for (int i = 0; i < 6; i++) begin
         push(1'b1, (i == 5) ? 3'd5 : 3'(4 - i), 2'd0, 1'b0, 1'b0, cyc + LAT);
         press(1, 10, 12);
      end

      // PLUS with 2-cycle bounce on press and release: one strobe
      btn_n[2] = 1'b0; step(2);
      btn_n[2] = 1'b1; step(2);
      btn_n[2] = 1'b0; step(2);
      btn_n[2] = 1'b1; step(1);
      push(1'b1, 3'd5, 2'd0, 1'b1, 1'b0, cyc + LAT);
      press(2, 10, 2);
      btn_n[2] = 1'b0; step(2);
      btn_n[2] = 1'b1; step(10);

      // PLUS+MINUS together: no strobe, timer reloaded, then timeout
      n = cyc;
      btn_n[3:2] = 2'b00;
      push(1'b0, 3'd5, 2'd0, 1'b0, 1'b0, n + LAT + T);
      step(10);
      btn_n[3:2] = 2'b11;
      step(60);

      // RUN: NEXT x3 wraps screen 1,2,0; PLUS ignored
      for (int i = 1; i <= 3; i++) begin
         push(1'b0, 3'd5, 2'(i % 3), 1'b0, 1'b0, cyc + LAT);
         press(1, 10, 12);
      end
      press(2, 10, 12);

      // Reset mid-EDIT with PLUS (and MODE) held
      push(1'b1, 3'd5, 2'd0, 1'b0, 1'b0, cyc + LAT);
      press(0, 10, 12);
      push(1'b1, 3'd5, 2'd0, 1'b1, 1'b0, cyc + LAT);
      btn_n[2] = 1'b0;
      step(10);
      btn_n[0] = 1'b0;
      push(1'b0, 3'd5, 2'd0, 1'b0, 1'b0, -1);
      #2 reset = 1'b0;
      step(3);
      check_reset_values();
      #2 reset = 1'b1;
      step(20);                      // both still held: no event allowed
      btn_n = 4'hF;
      step(12);
      push(1'b1, 3'd5, 2'd0, 1'b0, 1'b0, cyc + LAT);
      press(0, 10, 12);
      push(1'b1, 3'd5, 2'd0, 1'b1, 1'b0, cyc + LAT);
      press(2, 10, 12);
      push(1'b0, 3'd5, 2'd0, 1'b0, 1'b0, cyc + LAT);
      press(0, 10, 12);
      step(10);

      chk("scoreboard_drain", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
